// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 types and constants for the IR prefetch slice
// Contents:
//   lc3_opcode_t      - 4-bit LC-3 opcode encoding (IR[15:12])
//   LC3_WORD_W        - native LC-3 instruction word width
//   LC3_DEFAULT_DEPTH - default prefetch queue depth
package lc3_pkg;

    localparam int LC3_WORD_W        = 16;
    localparam int LC3_DEFAULT_DEPTH = 4;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3_opcode_t;

endpackage

// File: rtl/lc3_ir_store.sv
// rtl/lc3_ir_store.sv - circular storage array with head/tail pointers for the IR queue
// Ports:
//   clk, rst    - clock, synchronous active-low reset (pointers only)
//   clr_i       - return both pointers to 0 (flush)
//   wr_en_i     - write wr_data_i at the tail and advance the tail
//   wr_data_i   - word to write
//   rd_en_i     - advance the head (entry consumed)
//   head_o      - asynchronous read of the entry at the head
module lc3_ir_store
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_WORD_W,
    parameter int DEPTH  = LC3_DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     head_ptr_q, head_ptr_d;
    logic [PW-1:0]     tail_ptr_q, tail_ptr_d;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_comb begin
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        if (clr_i) begin
            head_ptr_d = '0;
            tail_ptr_d = '0;
        end else begin
            if (rd_en_i) head_ptr_d = head_ptr_q + PW'(1);
            if (wr_en_i) tail_ptr_d = tail_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
        end
    end

    // Array contents are don't-care until written; no reset needed.
    always_ff @(posedge clk) begin
        if (rst && !clr_i && wr_en_i) mem_q[tail_ptr_q] <= wr_data_i;
    end

    assign head_o = mem_q[head_ptr_q];

endmodule

// File: rtl/lc3_ir_prefetch.sv
// rtl/lc3_ir_prefetch.sv - LC-3 instruction prefetch queue feeding the IR
// Optional feature macro: LC3_IR_BYPASS_EN (empty-queue combinational bypass).
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   main_bus   - instruction word offered for load
//   ld_valid   - load offered this cycle; ld_ready - queue accepts a load
//   ir_take    - consumer takes the head; flush - discard queued entries
//   ir_valid   - IR_out holds an untaken instruction
//   IR_out     - head instruction, or last taken word when empty
//   opcode     - IR_out top nibble
//   count      - number of queued entries
//   drop_err   - sticky: load offered while full
module lc3_ir_prefetch
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_WORD_W,
    parameter int DEPTH  = LC3_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        main_bus,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic                     ir_take,
    input  logic                     flush,
    output logic                     ir_valid,
    output logic [DATA_W-1:0]        IR_out,
    output logic [3:0]               opcode,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] head;
    logic              q_empty;
    logic              bypass_hit;
    logic              take_fire;
    logic              push;
    logic              pop;

    assign q_empty  = (count_q == '0);
    assign ld_ready = (count_q < CW'(DEPTH));

`ifdef LC3_IR_BYPASS_EN
    // An offered word into an empty queue is presented straight to the IR.
    assign bypass_hit = q_empty & ld_valid & ~flush;
    assign ir_valid   = ~q_empty | bypass_hit;
    assign IR_out     = bypass_hit ? main_bus : (q_empty ? hold_q : head);
`else
    assign bypass_hit = 1'b0;
    assign ir_valid   = ~q_empty;
    assign IR_out     = q_empty ? hold_q : head;
`endif

    assign opcode = IR_out[DATA_W-1 -: 4];
    assign count  = count_q;

    assign take_fire = ir_take & ir_valid & ~flush;
    // A bypassed word that is taken in the same cycle never enters the queue.
    assign push      = ld_valid & ld_ready & ~flush & ~(bypass_hit & ir_take);
    assign pop       = take_fire & ~q_empty;

    always_comb begin
        count_d = count_q;
        hold_d  = hold_q;
        drop_d  = drop_q;
        if (flush) begin
            // Capture the visible word so IR_out is unchanged once the queue empties.
            count_d = '0;
            hold_d  = IR_out;
        end else begin
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
            if (take_fire)           hold_d = IR_out;
            if (ld_valid && !ld_ready) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_err = drop_q;

    lc3_ir_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .wr_en_i   (push),
        .wr_data_i (main_bus),
        .rd_en_i   (pop),
        .head_o    (head)
    );

endmodule

// File: doc/lc3_ir_prefetch.md
LC3_IR_PREFETCH -- requirements
Module: lc3_ir_prefetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the instruction word width (16 or greater).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the queue entry count (power of two, 2 or greater).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port main_bus, input, DATA_W bits: instruction word offered for load.
REQ-006 SHALL have port ld_valid, input, 1 bit: a load is offered on main_bus this cycle.
REQ-007 SHALL have port ld_ready, output, 1 bit: the queue accepts a load this cycle.
REQ-008 SHALL have port ir_take, input, 1 bit: the consumer takes the head instruction this cycle.
REQ-009 SHALL have port flush, input, 1 bit: discard all queued instructions.
REQ-010 SHALL have port ir_valid, output, 1 bit: IR_out holds an untaken queued instruction.
REQ-011 SHALL have port IR_out, output, DATA_W bits: the head instruction, or the last taken instruction when the queue is empty.
REQ-012 SHALL have port opcode, output, 4 bits: IR_out[DATA_W-1:DATA_W-4].
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of queued entries.
REQ-014 SHALL have port drop_err, output, 1 bit: sticky flag, set when a load is offered while the queue is full.

Function
REQ-015 SHALL accept a load when ld_valid and ld_ready are both 1.
- ld_ready = (count < DEPTH).
- ld_ready SHALL depend on registered state only.
REQ-016 SHALL complete a take when ir_take and ir_valid are both 1; ir_take while ir_valid is 0 SHALL be ignored.
REQ-017 SHALL hold queued entries in FIFO order; head and tail pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL handle a simultaneous accept and take as follows: count unchanged, head advances, tail advances.
REQ-019 SHALL ignore a load offered when full, even if a take occurs in the same cycle, and SHALL set drop_err.
REQ-020 SHALL, without bypass, assert ir_valid one cycle after the first accept into an empty queue.
REQ-021 SHALL, when the queue is empty, hold IR_out at the last taken word; IR_out is therefore driven from a dedicated holding register updated on every take.
REQ-022 SHALL give flush priority over loads and takes in the same cycle.
- Next state: count=0, pointers=0, ir_valid=0.
- IR_out and drop_err unchanged.
- ld_ready is 1 in the following cycle.
REQ-023 SHALL never let count exceed DEPTH or go below 0.

Reset
REQ-024 SHALL, while rst=0 at a clock edge, set count=0, pointers=0, IR_out=0, ir_valid=0 and drop_err=0; opcode is then 0 and ld_ready is 1.
REQ-025 SHALL let rst=0 override flush, load and take in the same cycle, and SHALL discard a queue in mid-operation.
REQ-026 SHALL not require reset of the storage array contents.

Configuration
REQ-027 SHALL support the macro LC3_IR_BYPASS_EN.
- Defined: when count=0 and ld_valid=1 (flush=0), ir_valid=1 and IR_out=main_bus combinationally.
- Defined, with ir_take=1 in that cycle: the word is consumed and not written into the queue, count stays 0, and the holding register captures main_bus.
- Undefined: no combinational path from main_bus or ld_valid to any output (REQ-020 latency applies).

Structure
REQ-028 SHALL place the following in shared package lc3_pkg:
- lc3_opcode_t enum (4-bit LC-3 opcodes);
- LC3_WORD_W=16;
- default DEPTH constant.
REQ-029 SHALL implement the storage array and its pointers as sub-module lc3_ir_store (write port plus asynchronous head read).

Verification
REQ-030 SHALL cover reset: rst=0 for 2 cycles, then 1 -> IR_out=16'h0000, ir_valid=0, count=0, ld_ready=1, drop_err=0.
REQ-031 SHALL cover FIFO order and wrap-around.
- Stimulus: with DEPTH=4, load 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, then take 4, repeated twice.
- Response: words come out in order, count peaks at 4, pointers wrap without loss.
REQ-032 SHALL cover full-queue drop.
- Stimulus: 4 loads, then a fifth load of 16'hFFFF with ir_take=1 in the same cycle.
- Response: 16'hFFFF is not queued, drop_err=1, count=3.
REQ-033 SHALL cover flush with simultaneous events.
- Stimulus: count=2, IR_out=16'h1234; flush=1 with ld_valid=1 and ir_take=1.
- Response: next cycle count=0, ir_valid=0, IR_out=16'h1234.
REQ-034 SHALL cover empty-queue hold and opcode.
- Stimulus: take 16'hF025, leaving the queue empty.
- Response: IR_out stays 16'hF025, opcode=4'hF, ir_valid=0.
REQ-035 SHALL cover bypass behaviour.
- Stimulus: empty queue, load 16'h2A05 with ir_take=1.
- With LC3_IR_BYPASS_EN: ir_valid=1 and IR_out=16'h2A05 in the same cycle, count remains 0.
- Without the macro: ir_valid rises one cycle later.
